// File: rtl/rpn_pkg.sv
// Shared types and constants for the RPN sequencer: FSM state encoding,
// operator opcodes and default sizing.
package rpn_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PUSH  = 3'd1,
    POP_B = 3'd2,
    POP_A = 3'd3,
    EXEC  = 3'd4,
    ERR   = 3'd5
  } state_t;

endpackage

// File: rtl/rpn_sequencer_if.sv
// Bundle between the RPN sequencer, its token source and its external stack.
// Handshake: a token transfers on a rising clk edge where tok_valid && tok_ready;
// the source holds tok_is_op/tok_dat stable while tok_valid is high, and
// tok_ready never depends combinationally on tok_valid.
interface rpn_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
);
  localparam int DEPTH_W = $clog2(DEPTH) + 1;

  logic              tok_valid;
  logic              tok_ready;
  logic              tok_is_op;
  logic [DATA_W-1:0] tok_dat;
  logic              push_stb;
  logic [DATA_W-1:0] push_dat;
  logic              pop_stb;
  logic [DATA_W-1:0] pop_dat;
  logic              res_valid;
  logic [DATA_W-1:0] res_dat;
  logic [DEPTH_W-1:0] depth;
  logic              err;
  logic              err_clr;

  // master: token source plus stack model; slave: the sequencer itself
  modport master (
    output tok_valid, tok_is_op, tok_dat, pop_dat, err_clr,
    input  tok_ready, push_stb, push_dat, pop_stb, res_valid, res_dat, depth, err
  );

  modport slave (
    input  tok_valid, tok_is_op, tok_dat, pop_dat, err_clr,
    output tok_ready, push_stb, push_dat, pop_stb, res_valid, res_dat, depth, err
  );

endinterface

// File: rtl/rpn_alu.sv
// Combinational RPN operator datapath; all results wrap modulo 2^DATA_W.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] r
);

  always_comb begin
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MUL:  r = a * b;
      OP_AND:  r = a & b;
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/rpn_sequencer.sv
// RPN token sequencer: pushes operands onto an external stack, and for operators
// pops B then A, evaluates A op B and pushes the result back.
module rpn_sequencer
  import rpn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  rpn_sequencer_if.slave bus,
  output state_t         o_state
);

  localparam int DEPTH_W = $clog2(DEPTH) + 1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_TWO = DEPTH_W'(2);

  state_t             r_state;
  logic               r_tok_ready;
  logic               r_push_stb;
  logic               r_pop_stb;
  logic               r_res_valid;
  logic               r_err;
  logic [DATA_W-1:0]  r_push_dat;
  logic [DATA_W-1:0]  r_res_dat;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [1:0]         r_op;
  logic [DEPTH_W-1:0] r_depth;

  logic [DATA_W-1:0]  w_alu_r;
  logic               w_accept;

  assign w_accept = bus.tok_valid && r_tok_ready;

  rpn_alu #(.DATA_W(DATA_W)) u_alu (
    .a  (r_a),
    .b  (r_b),
    .op (r_op),
    .r  (w_alu_r)
  );

  // Every output is registered for the state being entered, so strobes line
  // up exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_tok_ready <= 1'b0;
      r_push_stb  <= 1'b0;
      r_pop_stb   <= 1'b0;
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
      r_push_dat  <= '0;
      r_res_dat   <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= OP_ADD;
    end else begin
      r_push_stb  <= 1'b0;
      r_pop_stb   <= 1'b0;
      r_res_valid <= 1'b0;
      r_tok_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (!bus.tok_is_op) begin
              if (r_depth == DEPTH_MAX) begin
                r_err   <= 1'b1;
                r_state <= ERR;
              end else begin
                r_push_dat <= bus.tok_dat;
                r_push_stb <= 1'b1;
                r_state    <= PUSH;
              end
            end else if (r_depth < DEPTH_TWO) begin
              r_err   <= 1'b1;
              r_state <= ERR;
            end else begin
              r_op      <= bus.tok_dat[1:0];
              r_pop_stb <= 1'b1;
              r_state   <= POP_B;
            end
          end else begin
            r_tok_ready <= 1'b1;
          end
        end
        POP_B: begin
          r_b       <= bus.pop_dat;
          r_pop_stb <= 1'b1;
          r_state   <= POP_A;
        end
        POP_A: begin
          r_a     <= bus.pop_dat;
          r_state <= EXEC;
        end
        EXEC: begin
          r_push_dat  <= w_alu_r;
          r_res_dat   <= w_alu_r;
          r_push_stb  <= 1'b1;
          r_res_valid <= 1'b1;
          r_state     <= PUSH;
        end
        PUSH: begin
          r_tok_ready <= 1'b1;
          r_state     <= IDLE;
        end
        ERR: begin
          if (bus.err_clr) begin
            r_err       <= 1'b0;
            r_tok_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Depth tracks the stack as seen after each strobe cycle completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_depth <= '0;
    end else if (r_push_stb && (r_depth != DEPTH_MAX)) begin
      r_depth <= r_depth + 1'b1;
    end else if (r_pop_stb && (r_depth != '0)) begin
      r_depth <= r_depth - 1'b1;
    end
  end

  assign bus.tok_ready = r_tok_ready;
  assign bus.push_stb  = r_push_stb;
  assign bus.push_dat  = r_push_dat;
  assign bus.pop_stb   = r_pop_stb;
  assign bus.res_valid = r_res_valid;
  assign bus.res_dat   = r_res_dat;
  assign bus.depth     = r_depth;
  assign bus.err       = r_err;
  assign o_state       = r_state;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Bench for rpn_sequencer: an external stack, a token-level reference model
// checked every cycle, and directed RPN programs with literal results.
`timescale 1ns/1ps
module tb_rpn_sequencer;
  import rpn_pkg::*;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 16;
  localparam int DEPTH_W = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rpn_sequencer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
  state_t dbg_state;

  rpn_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .o_state (dbg_state)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- external stack ----------------
  logic [DATA_W-1:0] stk_mem [DEPTH];
  int stk_sp;
  assign bus.pop_dat = (stk_sp > 0) ? stk_mem[stk_sp-1] : '0;

  initial begin
    stk_sp = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) stk_sp <= 0;
      else if (bus.push_stb && stk_sp < DEPTH) begin
        stk_mem[stk_sp] <= bus.push_dat;
        stk_sp <= stk_sp + 1;
      end else if (bus.pop_stb && stk_sp > 0) begin
        stk_sp <= stk_sp - 1;
      end
    end
  end

  // ---------------- reference model ----------------
  // Works per accepted token: updates a logical stack and schedules the
  // visible strobe/depth events by cycle index relative to the accept edge.
  logic [DATA_W-1:0] m_stk[$];
  int  ecnt;
  int  ready_at;
  bit  m_err;
  int  m_depth;
  logic [DATA_W-1:0] m_pushdat;
  logic [DATA_W-1:0] m_res;
  logic [DATA_W-1:0] push_sched[int];
  logic [DATA_W-1:0] res_sched[int];
  bit  pop_sched[int];
  int  dep_delta[int];

  function automatic bit m_ready(input int c);
    return !m_err && (c >= ready_at);
  endfunction

  function automatic logic [DATA_W-1:0] rpn_eval(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [1:0] op);
    logic [63:0] prod;
    prod = 64'(a) * 64'(b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return prod[DATA_W-1:0];
      default: return a & b;
    endcase
  endfunction

  task automatic add_delta(input int k, input int d);
    if (dep_delta.exists(k)) dep_delta[k] = dep_delta[k] + d;
    else dep_delta[k] = d;
  endtask

  task automatic model_reset();
    m_stk.delete();
    push_sched.delete();
    res_sched.delete();
    pop_sched.delete();
    dep_delta.delete();
    ecnt      = 0;
    ready_at  = 1;
    m_err     = 0;
    m_depth   = 0;
    m_pushdat = '0;
    m_res     = '0;
  endtask

  task automatic model_edge();
    int e;
    logic [DATA_W-1:0] a, b, r;
    e = ecnt + 1;
    if (bus.tok_valid && m_ready(ecnt)) begin
      if (!bus.tok_is_op) begin
        if (m_stk.size() == DEPTH) m_err = 1;
        else begin
          m_stk.push_back(bus.tok_dat);
          push_sched[e] = bus.tok_dat;
          add_delta(e + 1, 1);
          ready_at = e + 1;
        end
      end else if (m_stk.size() < 2) begin
        m_err = 1;
      end else begin
        b = m_stk.pop_back();
        a = m_stk.pop_back();
        r = rpn_eval(a, b, bus.tok_dat[1:0]);
        m_stk.push_back(r);
        pop_sched[e]     = 1;
        pop_sched[e + 1] = 1;
        push_sched[e + 3] = r;
        res_sched[e + 3]  = r;
        add_delta(e + 1, -1);
        add_delta(e + 2, -1);
        add_delta(e + 4, 1);
        ready_at = e + 4;
      end
    end else if (m_err && bus.err_clr) begin
      m_err    = 0;
      ready_at = e;
    end
    ecnt = e;
    if (dep_delta.exists(e))  m_depth   = m_depth + dep_delta[e];
    if (push_sched.exists(e)) m_pushdat = push_sched[e];
    if (res_sched.exists(e))  m_res     = res_sched[e];
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_edge();
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [DATA_W-1:0] obs_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int n_push = 0;
  int n_pop  = 0;

  initial begin
    forever begin
      @(negedge clk);
      check("tok_ready", 64'(bus.tok_ready), 64'(m_ready(ecnt)));
      check("push_stb",  64'(bus.push_stb),  64'(push_sched.exists(ecnt)));
      check("pop_stb",   64'(bus.pop_stb),   64'(pop_sched.exists(ecnt)));
      check("res_valid", 64'(bus.res_valid), 64'(res_sched.exists(ecnt)));
      check("push_dat",  64'(bus.push_dat),  64'(m_pushdat));
      check("res_dat",   64'(bus.res_dat),   64'(m_res));
      check("depth",     64'(bus.depth),     64'(m_depth));
      check("err",       64'(bus.err),       64'(m_err));
      if (bus.push_stb) begin
        n_push++;
        obs_q.push_back(bus.push_dat);
      end
      if (bus.pop_stb) n_pop++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input bit is_op, input logic [DATA_W-1:0] d);
    bit done;
    done = 0;
    @(negedge clk);
    bus.tok_valid = 1'b1;
    bus.tok_is_op = is_op;
    bus.tok_dat   = d;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.tok_ready) begin
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check("accept_timeout", 64'(0), 64'(1));
    #1;
    bus.tok_valid = 1'b0;
  endtask

  task automatic wait_res(input string name, input logic [DATA_W-1:0] exp);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        check(name, 64'(bus.res_dat), 64'(exp));
        seen = 1;
      end
    end
    if (!seen) check({name, "_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int i = 0; i < 20 && !idle; i++) begin
      @(negedge clk);
      idle = bus.tok_ready || bus.err;
    end
    if (!idle) check("idle_timeout", 64'(0), 64'(1));
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed programs ----------------
  initial begin
    int np;
    rst_n         = 1'b0;
    bus.tok_valid = 1'b0;
    bus.tok_is_op = 1'b0;
    bus.tok_dat   = '0;
    bus.err_clr   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tok_ready", 64'(bus.tok_ready), 64'(0));
    check("rst_depth",     64'(bus.depth),     64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("first_ready",   64'(bus.tok_ready), 64'(1));

    // 3 4 + : pushes 3, 4, 7 and leaves one entry
    obs_q.delete();
    exp_q = '{32'd3, 32'd4, 32'd7};
    send(0, 32'd3);
    send(0, 32'd4);
    send(1, 32'(OP_ADD));
    wait_res("add_3_4", 32'd7);
    wait_idle();
    check("add_depth", 64'(bus.depth), 64'(1));
    check("add_push_cnt", 64'(obs_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i])
      if (i < obs_q.size()) check("add_push_seq", 64'(obs_q[i]), 64'(exp_q[i]));

    // err_clr while not in error must do nothing
    pulse_err_clr();

    send(0, 32'd10);
    send(0, 32'd3);
    send(1, 32'(OP_SUB));
    wait_res("sub_10_3", 32'd7);
    send(0, 32'd3);
    send(0, 32'd10);
    send(1, 32'(OP_SUB));
    wait_res("sub_3_10", 32'hFFFF_FFF9);
    send(0, 32'h1_0000);
    send(0, 32'h1_0000);
    send(1, 32'(OP_MUL));
    wait_res("mul_wrap", 32'd0);
    send(0, 32'hF0);
    send(0, 32'h3C);
    send(1, 32'(OP_AND));
    wait_res("and_f0_3c", 32'h30);
    wait_idle();
    check("chain_depth", 64'(bus.depth), 64'(5));

    // underflow: single operand then operator
    do_reset();
    send(0, 32'd5);
    np = n_pop;
    send(1, 32'(OP_ADD));
    repeat (5) @(negedge clk);
    check("uflow_err",    64'(bus.err),       64'(1));
    check("uflow_no_pop", 64'(n_pop - np),    64'(0));
    check("uflow_depth",  64'(bus.depth),     64'(1));
    pulse_err_clr();
    @(negedge clk);
    check("uflow_clr_ready", 64'(bus.tok_ready), 64'(1));

    // overflow: 16 pushes then a 17th
    do_reset();
    for (int i = 0; i < DEPTH; i++) send(0, 32'(i + 100));
    wait_idle();
    check("full_depth", 64'(bus.depth), 64'(DEPTH));
    np = n_push;
    send(0, 32'd999);
    repeat (5) @(negedge clk);
    check("oflow_err",     64'(bus.err),       64'(1));
    check("oflow_no_push", 64'(n_push - np),   64'(0));
    check("oflow_depth",   64'(bus.depth),     64'(DEPTH));
    check("oflow_ready",   64'(bus.tok_ready), 64'(0));
    pulse_err_clr();
    @(negedge clk);
    check("oflow_clr_ready", 64'(bus.tok_ready), 64'(1));
    check("oflow_clr_depth", 64'(bus.depth),     64'(DEPTH));
    check("oflow_clr_err",   64'(bus.err),       64'(0));

    // reset landing in POP_A of an ADD
    do_reset();
    send(0, 32'd1);
    send(0, 32'd1);
    send(1, 32'(OP_ADD));
    @(posedge clk);
    #1;
    check("in_pop_a", 64'(dbg_state), 64'(POP_A));
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(bus.tok_ready), 64'(0));
    check("mid_rst_push",  64'(bus.push_stb),  64'(0));
    check("mid_rst_pop",   64'(bus.pop_stb),   64'(0));
    check("mid_rst_resv",  64'(bus.res_valid), 64'(0));
    check("mid_rst_pdat",  64'(bus.push_dat),  64'(0));
    check("mid_rst_rdat",  64'(bus.res_dat),   64'(0));
    check("mid_rst_depth", 64'(bus.depth),     64'(0));
    check("mid_rst_err",   64'(bus.err),       64'(0));
    check("mid_rst_state", 64'(dbg_state),     64'(IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(0, 32'd2);
    send(0, 32'd2);
    send(1, 32'(OP_ADD));
    wait_res("post_rst_add", 32'd4);
    wait_idle();
    check("post_rst_depth", 64'(bus.depth), 64'(1));

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
